// File: rtl/gb_mem_pkg.sv
// gb_mem_pkg -- shared types and constants for the OAM DMA / SRAM arbitration
// slice.
//   dma_state_t  : DMA engine state encoding
//   OAM_BASE     : OAM destination base address
//   REG_DMA      : CPU address of the DMA source/trigger register
//   OAM_LEN      : bytes moved per DMA transfer
//   dma_src_addr : source address for a given page and byte index
package gb_mem_pkg;

  typedef enum logic [1:0] {
    DMA_IDLE  = 2'd0,
    DMA_START = 2'd1,
    DMA_READ  = 2'd2,
    DMA_WRITE = 2'd3
  } dma_state_t;

  localparam logic [15:0] OAM_BASE = 16'hFE00;
  localparam logic [15:0] REG_DMA  = 16'hFF46;
  localparam int          OAM_LEN  = 160;

  // The source never carries out of its page: the index simply fills the low byte.
  function automatic logic [15:0] dma_src_addr(input logic [7:0] page,
                                               input logic [7:0] idx);
    return {page, idx};
  endfunction

endpackage

// File: rtl/oam_dma_engine.sv
// oam_dma_engine -- OAM DMA sequencer. Copies DMA_LEN bytes from page src_q
// to DEST_BASE, alternating one READ and one WRITE cycle per byte after a
// single dead START cycle.
// Optional feature macro: OAM_DMA_RESTART_EN (a trigger while busy restarts
// the transfer from the new page; otherwise such a trigger is ignored).
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   trig          CPU write to the DMA register this cycle
//   trig_data     value written (new source page)
//   mem_rdata     SRAM read data (valid in the READ cycle)
//   active        engine is not idle
//   dma_addr      SRAM address requested by the engine
//   dma_re/dma_we SRAM read/write request from the engine
//   dma_wdata     SRAM write data (the byte captured in READ)
//   src           current source page register
module oam_dma_engine
  import gb_mem_pkg::*;
#(
  parameter int          DMA_LEN   = OAM_LEN,
  parameter logic [15:0] DEST_BASE = OAM_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trig,
  input  logic [7:0]  trig_data,
  input  logic [7:0]  mem_rdata,
  output logic        active,
  output logic [15:0] dma_addr,
  output logic        dma_re,
  output logic        dma_we,
  output logic [7:0]  dma_wdata,
  output logic [7:0]  src
);

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  dma_state_t state;
  logic [7:0] idx;
  logic [7:0] src_q;
  logic [7:0] buf_q;
  logic       restart;

`ifdef OAM_DMA_RESTART_EN
  assign restart = trig;
`else
  assign restart = 1'b0;
`endif

  // FSM with registered request outputs: each transition also loads the
  // address/enables that the next state must present to the SRAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DMA_IDLE;
      idx      <= 8'd0;
      src_q    <= 8'h00;
      buf_q    <= 8'h00;
      dma_addr <= 16'h0000;
      dma_re   <= 1'b0;
      dma_we   <= 1'b0;
    end else begin
      dma_re <= 1'b0;
      dma_we <= 1'b0;
      if ((state != DMA_IDLE) && restart) begin
        // The request already on the bus this cycle still completes; the
        // next cycle is a fresh START from the new page.
        state <= DMA_START;
        src_q <= trig_data;
        idx   <= 8'd0;
      end else begin
        case (state)
          DMA_IDLE: begin
            if (trig) begin
              state <= DMA_START;
              src_q <= trig_data;
              idx   <= 8'd0;
            end
          end
          DMA_START: begin
            state    <= DMA_READ;
            dma_re   <= 1'b1;
            dma_addr <= dma_src_addr(src_q, idx);
          end
          DMA_READ: begin
            buf_q    <= mem_rdata;
            state    <= DMA_WRITE;
            dma_we   <= 1'b1;
            dma_addr <= DEST_BASE + {8'h00, idx};
          end
          DMA_WRITE: begin
            if (idx == LAST_IDX) begin
              state <= DMA_IDLE;
              idx   <= 8'd0;
            end else begin
              idx      <= idx + 8'd1;
              state    <= DMA_READ;
              dma_re   <= 1'b1;
              dma_addr <= dma_src_addr(src_q, idx + 8'd1);
            end
          end
          default: begin
            state <= DMA_IDLE;
            idx   <= 8'd0;
          end
        endcase
      end
    end
  end

  assign active    = (state != DMA_IDLE);
  assign dma_wdata = buf_q;
  assign src       = src_q;

endmodule

// File: rtl/oam_dma_arbiter.sv
// oam_dma_arbiter -- owns the single SRAM port shared by the CPU datapath and
// the OAM DMA engine. Decodes the DMA register, muxes CPU/DMA onto the SRAM
// and stalls CPU memory accesses while a transfer is running.
// Optional feature macro: OAM_DMA_RESTART_EN (handled inside oam_dma_engine).
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   cpu_addr     CPU address
//   cpu_re       CPU read request
//   cpu_we       CPU write request (takes priority over cpu_re)
//   cpu_wdata    CPU write data
//   cpu_rdata    CPU read data (combinational)
//   cpu_stall    CPU access not serviced this cycle
//   mem_addr     SRAM address
//   mem_re       SRAM read enable
//   mem_we       SRAM write enable
//   mem_wdata    SRAM write data
//   mem_rdata    SRAM read data (asynchronous)
//   dma_active   a DMA transfer is in progress
module oam_dma_arbiter
  import gb_mem_pkg::*;
#(
  parameter int          DMA_LEN      = OAM_LEN,
  parameter logic [15:0] DEST_BASE    = OAM_BASE,
  parameter logic [15:0] DMA_REG_ADDR = REG_DMA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_re,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_stall,
  output logic [15:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        dma_active
);

  logic        reg_hit;
  logic        cpu_req;
  logic        reg_wr;
  logic [15:0] dma_addr;
  logic        dma_re;
  logic        dma_we;
  logic [7:0]  dma_wdata;
  logic [7:0]  dma_src;

  assign reg_hit = (cpu_addr == DMA_REG_ADDR);
  assign cpu_req = cpu_re | cpu_we;
  assign reg_wr  = reg_hit & cpu_we;

  oam_dma_engine #(
    .DMA_LEN   (DMA_LEN),
    .DEST_BASE (DEST_BASE)
  ) u_engine (
    .clk       (clk),
    .rst       (rst),
    .trig      (reg_wr),
    .trig_data (cpu_wdata),
    .mem_rdata (mem_rdata),
    .active    (dma_active),
    .dma_addr  (dma_addr),
    .dma_re    (dma_re),
    .dma_we    (dma_we),
    .dma_wdata (dma_wdata),
    .src       (dma_src)
  );

  // Port mux and stall: the register never stalls and never reaches SRAM;
  // any other CPU access waits (and is dropped) until the engine is idle.
  always_comb begin
    cpu_stall = dma_active & cpu_req & ~reg_hit;
    if (reg_hit) begin
      cpu_rdata = dma_src;
    end else begin
      cpu_rdata = mem_rdata;
    end

    if (dma_active) begin
      mem_addr  = dma_addr;
      mem_re    = dma_re;
      mem_we    = dma_we;
      mem_wdata = dma_wdata;
    end else if (reg_hit) begin
      mem_addr  = cpu_addr;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      mem_wdata = cpu_wdata;
    end else begin
      mem_addr  = cpu_addr;
      mem_re    = cpu_re & ~cpu_we;
      mem_we    = cpu_we;
      mem_wdata = cpu_wdata;
    end
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// tb_oam_dma_arbiter -- scoreboard bench for oam_dma_arbiter with a behavioural
// 64 KiB asynchronous-read SRAM. Honours OAM_DMA_RESTART_EN for the expected
// outcome of a register write during a transfer.
module tb_oam_dma_arbiter;

`ifdef OAM_DMA_RESTART_EN
  localparam bit RESTART = 1'b1;
`else
  localparam bit RESTART = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic        cpu_re;
  logic        cpu_we;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_stall;
  logic [15:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        dma_active;

  oam_dma_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_addr   (cpu_addr),
    .cpu_re     (cpu_re),
    .cpu_we     (cpu_we),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .mem_addr   (mem_addr),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .dma_active (dma_active)
  );

  always #5 clk = ~clk;

  // Initial SRAM image: page C1 holds i^A5, every other page holds i^page.
  function automatic logic [7:0] init_val(input logic [15:0] a);
    if (a[15:8] == 8'hC1) return a[7:0] ^ 8'hA5;
    else return a[7:0] ^ a[15:8];
  endfunction

  logic [7:0] mem [0:65535];
  logic       mem_clr;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int a = 0; a < 65536; a++) mem[a] <= init_val(16'(a));
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  typedef struct {
    string       name;
    logic        is_wr;
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   act_cnt = 0;
  int   last_len = 0;
  bit   arm_re = 1'b0;
  int   first_re_cyc = -1;
  int   trig_cyc = 0;
  int   leak_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input string name, input logic wr, input logic [15:0] a, input logic [7:0] d);
    exp_t e;
    e.name = name; e.is_wr = wr; e.addr = a; e.data = d;
    sbq.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Issue one CPU access and hold it until it is serviced (bounded).
  task automatic cpu_access(input logic wr, input logic [15:0] a, input logic [7:0] d,
                            output int stalled, output logic svc_active);
    cpu_addr = a; cpu_we = wr; cpu_re = !wr; cpu_wdata = d; stalled = 0;
    @(negedge clk);
    while (cpu_stall && stalled < 2000) begin
      stalled++;
      @(negedge clk);
    end
    svc_active = dma_active;
    if (cpu_stall) begin
      total++; bad++;
      $display("FAIL stall_timeout addr=%h stalled=%0d", a, stalled);
    end
    @(posedge clk); #1;
    cpu_re = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic trigger(input logic [7:0] page);
    int st; logic sa;
    trig_cyc = cyc;
    arm_re = 1'b1;
    cpu_access(1'b1, 16'hFF46, page, st, sa);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (dma_active && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (dma_active) begin
      total++; bad++;
      $display("FAIL %s dma_active still high after %0d cycles", name, k);
    end
    @(posedge clk); #1;
  endtask

  // OAM byte i must equal i ^ (i < n_lo ? key_lo : key_hi).
  task automatic check_oam(input string name, input logic [7:0] key_lo, input int n_lo,
                           input logic [7:0] key_hi);
    int errs = 0;
    logic [7:0] e;
    for (int i = 0; i < 160; i++) begin
      e = 8'(i) ^ ((i < n_lo) ? key_lo : key_hi);
      if (mem[16'hFE00 + 16'(i)] !== e) errs++;
    end
    chk(name, errs, 0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops the scoreboard for every serviced CPU access and tracks DMA activity.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if ((cpu_re || cpu_we) && !cpu_stall && !(cpu_we && cpu_addr == 16'hFF46)) begin
          if (sbq.size() == 0) begin
            total++; bad++;
            $display("FAIL sb_unexpected addr=%h", cpu_addr);
          end else begin
            e = sbq.pop_front();
            if (e.is_wr) begin
              chk({e.name, "_we"}, mem_we, 1'b1);
              chk({e.name, "_addr"}, mem_addr, e.addr);
              chk({e.name, "_wdata"}, mem_wdata, e.data);
            end else begin
              chk({e.name, "_rdata"}, cpu_rdata, e.data);
            end
          end
        end
        if (dma_active) begin
          act_cnt++;
          if (mem_re && mem_we) leak_cnt++;
          else if (mem_re && !(mem_addr[15:8] == 8'hC1 || mem_addr[15:8] == 8'hD2 ||
                               mem_addr[15:8] == 8'hE0)) leak_cnt++;
          else if (mem_we && !(mem_addr >= 16'hFE00 && mem_addr <= 16'hFE9F)) leak_cnt++;
        end else if (act_cnt != 0) begin
          last_len = act_cnt;
          act_cnt = 0;
        end
        if (arm_re && mem_re) begin
          first_re_cyc = cyc;
          arm_re = 1'b0;
        end
      end
    end
  end

  initial begin
    int   st;
    logic sa;
    logic [7:0] key4;
    rst = 1'b1; mem_clr = 1'b1;
    cpu_addr = 16'h1234; cpu_re = 1'b0; cpu_we = 1'b0; cpu_wdata = 8'h77;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_active", dma_active, 1'b0);
    chk("rst_stall", cpu_stall, 1'b0);
    chk("rst_mem_re", mem_re, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h1234);
    chk("rst_mem_wdata", mem_wdata, 8'h77);
    @(posedge clk); #1;
    rst = 1'b0; mem_clr = 1'b0;

    // Idle behaviour: register read, passthrough write/read
    push("rd_src_rst", 1'b0, 16'hFF46, 8'h00);
    cpu_access(1'b0, 16'hFF46, 8'h00, st, sa);
    push("wr_idle", 1'b1, 16'hD000, 8'h5A);
    cpu_access(1'b1, 16'hD000, 8'h5A, st, sa);
    chk("wr_idle_stall", st, 0);
    push("rd_idle_d000", 1'b0, 16'hD000, 8'h5A);
    cpu_access(1'b0, 16'hD000, 8'h00, st, sa);
    push("rd_idle_c000", 1'b0, 16'hC000, 8'hC0);
    cpu_access(1'b0, 16'hC000, 8'h00, st, sa);

    // Full transfer from page C1
    trigger(8'hC1);
    wait_idle("t1_idle");
    chk("t1_active_len", last_len, 321);
    chk("t1_first_re", first_re_cyc - trig_cyc, 2);
    check_oam("t1_oam", 8'hA5, 160, 8'hA5);
    chk("t1_fea0_untouched", mem[16'hFEA0], 8'h5E);
    chk("t1_fdff_untouched", mem[16'hFDFF], 8'h02);

    // Register read and stalled read during a transfer
    trigger(8'hC1);
    push("t3_rd_reg", 1'b0, 16'hFF46, 8'hC1);
    cpu_access(1'b0, 16'hFF46, 8'h00, st, sa);
    chk("t3_reg_stall", st, 0);
    push("t2_rd_stalled", 1'b0, 16'hC000, 8'hC0);
    cpu_access(1'b0, 16'hC000, 8'h00, st, sa);
    chk("t2_stall_cycles", st, 320);
    chk("t2_svc_idle", sa, 1'b0);
    chk("t2_active_len", last_len, 321);

    // Register write at idx 40 (READ cycle N+82)
    trigger(8'hC1);
    tick(81);
    cpu_access(1'b1, 16'hFF46, 8'hD2, st, sa);
    chk("t4_wr_stall", st, 0);
    wait_idle("t4_idle");
    chk("t4_active_len", last_len, RESTART ? 403 : 321);
    key4 = RESTART ? 8'hD2 : 8'hA5;
    check_oam("t4_oam", key4, 160, key4);
    push("t4_rd_src", 1'b0, 16'hFF46, RESTART ? 8'hD2 : 8'hC1);
    cpu_access(1'b0, 16'hFF46, 8'h00, st, sa);

    // Reset during READ of idx 50 (cycle N+102)
    trigger(8'hE0);
    tick(101);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_read_re", mem_re, 1'b1);
    chk("t5_read_addr", mem_addr, 16'hE032);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_rst_active", dma_active, 1'b0);
    chk("t5_rst_we", mem_we, 1'b0);
    chk("t5_rst_re", mem_re, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    check_oam("t5_oam", 8'hE0, 50, key4);
    push("t5_rd_src", 1'b0, 16'hFF46, 8'h00);
    cpu_access(1'b0, 16'hFF46, 8'h00, st, sa);

    tick(2);
    chk("no_cpu_leak", leak_cnt, 0);
    chk("sb_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
